// File: rtl/ir_move_transmitter_pkg.sv
// Shared types and protocol constants for the IR move transmitter.
// Unit counts are sized to compare directly against the 3-bit in-state unit counter.
package ir_move_transmitter_pkg;

    localparam int CMD_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SPACE,
        MARK,
        GAP
    } state_t;

    typedef logic [2:0] units_t;

    localparam units_t START_UNITS = 3'd4;
    localparam units_t SPACE_UNITS = 3'd1;
    localparam units_t ONE_UNITS   = 3'd2;
    localparam units_t ZERO_UNITS  = 3'd1;

    function automatic units_t mark_units(input logic bit_val);
        return bit_val ? ONE_UNITS : ZERO_UNITS;
    endfunction

endpackage

// File: rtl/ir_unit_timer.sv
// Protocol unit tick generator with synchronous restart.
// With IR_CARRIER_EN defined it also hosts the mark carrier divider.
module ir_unit_timer #(
    parameter int UNIT_CYCLES  = 16200,
    parameter int CARRIER_HALF = 338
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic unit_tick
`ifdef IR_CARRIER_EN
    ,
    input  logic carrier_restart,
    output logic carrier
`endif
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);

    if (CARRIER_HALF < 1) begin : g_bad_carrier
        $error("CARRIER_HALF must be at least 1");
    end

    logic [UW-1:0] unit_cnt;

    assign unit_tick = run && (unit_cnt == UNIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            unit_cnt <= '0;
        end else if (restart || unit_tick) begin
            unit_cnt <= '0;
        end else if (run) begin
            unit_cnt <= unit_cnt + UW'(1);
        end
    end

`ifdef IR_CARRIER_EN
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CW-1:0] CARRIER_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] phase_cnt;

    // Each mark begins on the high half of the carrier
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
            carrier   <= 1'b0;
        end else if (carrier_restart) begin
            phase_cnt <= '0;
            carrier   <= 1'b1;
        end else if (phase_cnt == CARRIER_LAST) begin
            phase_cnt <= '0;
            carrier   <= ~carrier;
        end else begin
            phase_cnt <= phase_cnt + CW'(1);
        end
    end
`endif

endmodule

// File: rtl/ir_move_transmitter.sv
// Serialises a 12-bit move command as repeated SIRC-style IR frames, LSB first.
// Optional carrier modulation of marks is enabled with the IR_CARRIER_EN macro.
module ir_move_transmitter
    import ir_move_transmitter_pkg::*;
#(
    parameter int UNIT_CYCLES  = 16200,
    parameter int FRAME_UNITS  = 75,
    parameter int REPEATS      = 3,
    parameter int CARRIER_HALF = 338
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CMD_W-1:0] move_command,
    output logic             busy,
    output logic             done,
    output logic             ir_out
);

    localparam int FU_W = $clog2(FRAME_UNITS + 1);
    localparam logic [FU_W-1:0] FRAME_LAST = FU_W'(FRAME_UNITS - 1);
    localparam logic [2:0]      REP_LAST   = 3'(REPEATS - 1);
    localparam logic [3:0]      BIT_LAST   = 4'(CMD_W - 1);

    if (REPEATS < 1 || REPEATS > 7) begin : g_bad_repeats
        $error("REPEATS must be in 1..7");
    end

    state_t            state, state_n;
    logic [CMD_W-1:0]  cmd_q, cmd_n;
    logic [3:0]        bit_idx, bit_n;
    logic [2:0]        rep_cnt, rep_n;
    units_t            state_units, su_n;
    logic [FU_W-1:0]   frame_units, fu_n;
    logic              busy_n, done_n;
    logic              accept, run, unit_tick, mark_on;

    // done blocks acceptance for its own cycle even though the FSM is already IDLE
    assign accept  = (state == IDLE) && enable && !done;
    assign run     = (state != IDLE);
    assign mark_on = (state == START) || (state == MARK);

`ifdef IR_CARRIER_EN
    logic mark_entry, carrier;

    assign mark_entry = (state_n != state) && ((state_n == START) || (state_n == MARK));
    assign ir_out     = mark_on & carrier;

    ir_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .CARRIER_HALF(CARRIER_HALF)
    ) u_timer (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .restart        (accept),
        .unit_tick      (unit_tick),
        .carrier_restart(mark_entry),
        .carrier        (carrier)
    );
`else
    assign ir_out = mark_on;

    ir_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .CARRIER_HALF(CARRIER_HALF)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .restart  (accept),
        .unit_tick(unit_tick)
    );
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_q       <= '0;
            bit_idx     <= '0;
            rep_cnt     <= '0;
            state_units <= '0;
            frame_units <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_q       <= cmd_n;
            bit_idx     <= bit_n;
            rep_cnt     <= rep_n;
            state_units <= su_n;
            frame_units <= fu_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cmd_n   = cmd_q;
        bit_n   = bit_idx;
        rep_n   = rep_cnt;
        su_n    = state_units;
        fu_n    = frame_units;
        busy_n  = busy;
        done_n  = 1'b0;

        // The frame counter spans the whole frame, so GAP absorbs whatever the bits left over
        if (unit_tick) begin
            su_n = state_units + 3'd1;
            fu_n = frame_units + FU_W'(1);
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    cmd_n   = move_command;
                    busy_n  = 1'b1;
                    rep_n   = '0;
                    bit_n   = '0;
                    su_n    = '0;
                    fu_n    = '0;
                end
            end
            START: begin
                if (unit_tick && state_units == START_UNITS - 3'd1) begin
                    state_n = SPACE;
                    su_n    = '0;
                    bit_n   = '0;
                end
            end
            SPACE: begin
                if (unit_tick && state_units == SPACE_UNITS - 3'd1) begin
                    state_n = MARK;
                    su_n    = '0;
                end
            end
            MARK: begin
                if (unit_tick && state_units == mark_units(cmd_q[bit_idx]) - 3'd1) begin
                    su_n = '0;
                    if (bit_idx < BIT_LAST) begin
                        bit_n   = bit_idx + 4'd1;
                        state_n = SPACE;
                    end else begin
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (unit_tick && frame_units == FRAME_LAST) begin
                    su_n = '0;
                    fu_n = '0;
                    if (rep_cnt < REP_LAST) begin
                        rep_n   = rep_cnt + 3'd1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
